serial_add_ctrl: RTL and testbench

Bit-serial adder controller that time-shares a single one-bit full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first.
- Operands and carry-in are accepted over a valid/ready handshake.
- The block sequences the cell, holds the running carry in a flop, and presents the finished sum and carry-out over a second valid/ready handshake.
- It is the area-minimal alternative to a WIDTH-bit ripple adder in the arithmetic datapath.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 107 ++++++++++
 tb/tb_serial_add_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and counter sizing.
package serial_add_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Counter must hold 0..WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder, the single arithmetic cell time-shared by the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller, LSB first, one bit per clock over valid/ready handshakes.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN (adds the sub port).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned       CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-1:0] b_ld;
  logic             carry;
  logic             carry_ld;
  logic [CntW-1:0]  cnt;
  logic             s;
  logic             co;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  // Subtraction is a + ~b + 1; cout then reads as "no borrow".
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_ld     = sub ? ~b : b;
    carry_ld = sub ? 1'b1 : cin;
`else
    b_ld     = b;
    carry_ld = cin;
`endif
  end

  always_comb begin
    sum_nx            = sum >> 1;
    sum_nx[WIDTH-1]   = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_ld;
            carry <= carry_ld;
            sum   <= '0;
            cnt   <= '0;
            state <= StRun;
          end
        end
        StRun: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= sum_nx;
          carry <= co;
          cnt   <= cnt + 1'b1;
          if (cnt == CntLast) begin
            cout  <= co;
            state <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state == StIdle) && !rst;
  assign out_valid = (state == StDone);
  assign busy      = (state == StRun) || (state == StDone);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed cases, backpressure, reset abort, random ops.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [WIDTH:0] res;
    int unsigned    acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  logic             in_valid1 = 1'b0;
  logic             in_ready1;
  logic [0:0]       a1 = 1'b0;
  logic [0:0]       b1 = 1'b0;
  logic             cin1 = 1'b0;
  logic             sub1 = 1'b0;
  logic             out_valid1;
  logic             out_ready1 = 1'b1;
  logic [0:0]       sum1;
  logic             cout1;
  logic             busy1;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned ready_mode = 0;
  logic        prev_ov = 1'b0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic ci, input logic sb);
    logic [WIDTH-1:0] d;
    if (sb) begin
      d = x - y;
      return {(x >= y), d};
    end
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pushes model results on accept, checks latency and pops on result handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready)
        sb_q.push_back('{res: model(a, b, cin, sub), acc: cyc + 1});
      if (out_valid && !prev_ov) begin
        if (sb_q.size() == 0) chk("unexpected_out_valid", 64'(sb_q.size()), 64'd1);
        else chk("latency", 64'(cyc - sb_q[0].acc), 64'(WIDTH));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_result", 64'(sb_q.size()), 64'd1);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", 64'({cout, sum}), 64'(e.res));
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                       input logic sb);
    logic got;
    got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    sub = sb;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] hold_s;
    logic             hold_c;
    logic             got;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed sums
    issue(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done();
    chk("dir_5a_3c", 64'({cout, sum}), 64'h096);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done();
    chk("dir_ff_01", 64'({cout, sum}), 64'h100);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_done();
    chk("dir_ff_ff_c", 64'({cout, sum}), 64'h1FF);

    // Backpressure: hold DONE while inputs toggle
    ready_mode = 2;
    repeat (2) @(posedge clk);
    issue(8'hA5, 8'h0F, 1'b1, 1'b0);
    wait_done();
    chk("bp_value", 64'({cout, sum}), 64'h0B5);
    hold_s = sum;
    hold_c = cout;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      chk("bp_sum_hold", 64'(sum), 64'(hold_s));
      chk("bp_cout_hold", 64'(cout), 64'(hold_c));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h44;
    cin = 1'b0;
    ready_mode = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("release_timeout", 64'(got), 64'd1);
    @(negedge clk);
    chk("post_release_in_ready", 64'(in_ready), 64'd1);
    chk("post_release_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("reaccept_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done();
    chk("reaccept_value", 64'({cout, sum}), 64'h077);

    // Reset in the middle of RUN
    issue(8'hC3, 8'h2D, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle_ready", 64'(in_ready), 64'd1);
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done();
    chk("abort_fresh", 64'({cout, sum}), 64'h002);

    // WIDTH=1 instance
    @(posedge clk);
    #1;
    in_valid1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b1;
    @(negedge clk);
    chk("w1_in_ready", 64'(in_ready1), 64'd1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("w1_busy", 64'(busy1), 64'd1);
    chk("w1_not_yet", 64'(out_valid1), 64'd0);
    @(negedge clk);
    chk("w1_out_valid", 64'(out_valid1), 64'd1);
    chk("w1_result", 64'({cout1, sum1}), 64'h3);

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done();
    chk("sub_10_01", 64'({cout, sum}), 64'h10F);
    issue(8'h00, 8'h01, 1'b1, 1'b1);
    wait_done();
    chk("sub_00_01", 64'({cout, sum}), 64'h0FF);
`endif

    // Random operations with random result stalls
    ready_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom % 3) @(posedge clk);
`ifdef SERIAL_ADD_SUB_EN
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
`else
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
`endif
    end
    ready_mode = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
